pix_frame_binarizer: RTL and testbench

- Upstream stage of the BNN classifier: accepts the raw 8-bit MNIST pixel stream, thresholds each pixel to one bit, and packs each 28x28 image into a 784-bit frame.
- Ping-pong buffered, so pixel intake continues while the classifier consumes the previous frame.
- Frame-level valid/ready handshake replaces the classifier's free-running modulo-784 pixel write.

---
 rtl/pix_frame_binarizer.sv | 122 ++++++++++++
 tb/tb_pix_frame_binarizer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_frame_binarizer.sv
// Thresholds an 8-bit raster pixel stream to one bit per pixel and packs
// each image into a ping-pong buffered frame with a valid/ready handshake.
module pix_frame_binarizer #(
  parameter int ROWS     = 28,
  parameter int COLS     = 28,
  parameter int WIDTH_IN = 784,
  parameter int PIX_BITS = 8,
  parameter int THRESH   = 64,
  parameter int CNT_BIT  = 16
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic [PIX_BITS-1:0] pix,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic                pix_ready,
  output logic [WIDTH_IN-1:0] frame_bits,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [CNT_BIT-1:0]  frame_cnt,
  output logic                short_err
);

  localparam int IW = $clog2(WIDTH_IN);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } buf_st_e;

  buf_st_e st_q [2];
  buf_st_e st_d [2];

  logic [WIDTH_IN-1:0] mem0, mem1;
  logic          wr_sel, rd_sel;
  logic          wr_sel_d, rd_sel_d;
  logic [IW-1:0] idx, idx_eff, idx_nx;
  logic [RW-1:0] row, row_eff, row_nx;
  logic [CW-1:0] col, col_eff, col_nx;
  logic          accept, rel, restart;
  logic          last, pix_bit, pix_ready_d;

  assign frame_valid = (st_q[rd_sel] == FULL);
  assign frame_bits  = rd_sel ? mem1 : mem0;

  always_comb begin
    accept  = pix_valid & pix_ready;
    rel     = frame_valid & frame_ready;
    pix_bit = (pix > PIX_BITS'(THRESH));
    // A start-of-frame beat always lands at position 0
    restart = accept & pix_sof & (idx != '0);
    idx_eff = pix_sof ? '0 : idx;
    row_eff = pix_sof ? '0 : row;
    col_eff = pix_sof ? '0 : col;
    last    = (row_eff == RW'(ROWS-1)) &&
              (col_eff == CW'(COLS-1));

    idx_nx = idx_eff + IW'(1);
    row_nx = row_eff;
    col_nx = col_eff + CW'(1);
    if (last) begin
      idx_nx = '0;
      row_nx = '0;
      col_nx = '0;
    end else if (col_eff == CW'(COLS-1)) begin
      row_nx = row_eff + RW'(1);
      col_nx = '0;
    end

    st_d = st_q;
    if (accept) begin
      st_d[wr_sel] = last ? FULL : FILLING;
    end
    if (rel) begin
      st_d[rd_sel] = EMPTY;
    end
    wr_sel_d    = wr_sel ^ (accept & last);
    rd_sel_d    = rd_sel ^ rel;
    pix_ready_d = (st_d[wr_sel_d] != FULL);
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      pix_ready <= 1'b0;
      frame_cnt <= '0;
      short_err <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_sel    <= wr_sel_d;
      rd_sel    <= rd_sel_d;
      pix_ready <= pix_ready_d;
      frame_cnt <= frame_cnt + CNT_BIT'(rel);
      short_err <= restart;
      if (accept) begin
        idx <= idx_nx;
        row <= row_nx;
        col <= col_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      mem0 <= '0;
      mem1 <= '0;
    end else if (accept) begin
      if (wr_sel) mem1[idx_eff] <= pix_bit;
      else        mem0[idx_eff] <= pix_bit;
    end
  end

endmodule

// File: tb/tb_pix_frame_binarizer.sv
// Scoreboard bench: a pixel model pushes expected frames on the last
// accepted pixel; the monitor pops and compares on every frame handshake.
module tb_pix_frame_binarizer;

  localparam int W = 784;

  logic          clk = 1'b0;
  logic          xrst = 1'b1;
  logic [7:0]    pix = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_ready;
  logic [W-1:0]  frame_bits;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [15:0]   frame_cnt;
  logic          short_err;

  pix_frame_binarizer dut (
    .clk         (clk),
    .xrst        (xrst),
    .pix         (pix),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .frame_bits  (frame_bits),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_cnt   (frame_cnt),
    .short_err   (short_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] sb [$];
  logic [W-1:0] mdl_frame = '0;
  logic [W-1:0] popped;
  logic [7:0]   pat [W];
  int mdl_idx = 0;
  int exp_serr = 0;
  int serr_seen = 0;
  int n_pushed = 0;
  int cyc = 0;
  int fr_mode = 0;
  int hs_cyc [$];

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    case (fr_mode)
      1:       frame_ready = 1'b1;
      2:       frame_ready = 1'($urandom_range(1, 0));
      default: frame_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!xrst) begin
      if (short_err) serr_seen++;
      if (frame_valid && frame_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("frame_expected", W'(sb.size()), W'(1));
        end else begin
          popped = sb.pop_front();
          check("frame_bits", frame_bits, popped);
        end
      end
    end
  end

  task automatic model_accept(input logic [7:0] p, input logic sof);
    if (sof && mdl_idx != 0) begin
      exp_serr++;
      mdl_idx = 0;
    end
    mdl_frame[mdl_idx] = (p > 8'd64);
    mdl_idx++;
    if (mdl_idx == W) begin
      sb.push_back(mdl_frame);
      n_pushed++;
      mdl_idx = 0;
    end
  endtask

  task automatic send_pix(input logic [7:0] p, input logic sof,
                          input logic gap);
    int n;
    logic rdy;
    if (gap) begin
      while ($urandom_range(1, 0) == 1) begin
        pix_valid = 1'b0;
        pix = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    pix = p;
    pix_sof = sof;
    pix_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = pix_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 3000);
    if (!rdy) check("accept_tmo", W'(rdy), W'(1));
    else model_accept(p, sof);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix = 8'($urandom);
  endtask

  task automatic send_frame(input logic sof, input logic gap);
    for (int i = 0; i < W; i++) send_pix(pat[i], sof && i == 0, gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || frame_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check("drain_tmo", W'(sb.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    xrst = 1'b1;
    #1;
    check("rst_fvalid", W'(frame_valid), W'(0));
    check("rst_bits", frame_bits, W'(0));
    check("rst_cnt", W'(frame_cnt), W'(0));
    check("rst_serr", W'(short_err), W'(0));
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b0;
    sb.delete();
    hs_cyc.delete();
    mdl_idx = 0;
    exp_serr = 0;
    serr_seen = 0;
    n_pushed = 0;
    @(posedge clk);
    #1;
    check("rst_pready", W'(pix_ready), W'(1));
  endtask

  logic [W-1:0] e;

  initial begin
    // Test 1: alternating 0x40/0x41, consumer always ready
    fr_mode = 1;
    do_reset();
    for (int i = 0; i < W; i++) pat[i] = (i % 2 == 1) ? 8'h41 : 8'h40;
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < W; i++) e[i] = (i % 2 == 1);
    check("t1_fvalid", W'(frame_valid), W'(1));
    check("t1_bits", frame_bits, e);
    @(negedge clk);
    check("t1_fvalid_low", W'(frame_valid), W'(0));
    check("t1_cnt", W'(frame_cnt), W'(1));
    check("t1_serr", W'(serr_seen), W'(0));

    // Test 2: threshold boundary at 64
    do_reset();
    for (int i = 0; i < W; i++) pat[i] = 8'h00;
    pat[1] = 8'h40;
    pat[27] = 8'h41;
    pat[783] = 8'hFF;
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    e = '0;
    e[27] = 1'b1;
    e[783] = 1'b1;
    check("t2_bits", frame_bits, e);
    drain();
    check("t2_cnt", W'(frame_cnt), W'(1));

    // Test 3: back-pressure with both buffers full
    fr_mode = 0;
    do_reset();
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int i = 0; i < W; i++) pat[i] = 8'($urandom);
          send_frame(1'b1, 1'b0);
        end
      end
      begin
        for (int n = 0; n < 5000 && n_pushed < 2; n++) @(posedge clk);
        @(negedge clk);
        check("t3_pready_drop", W'(pix_ready), W'(0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3_fvalid_hold", W'(frame_valid), W'(1));
        check("t3_pready_hold", W'(pix_ready), W'(0));
        fr_mode = 1;
      end
    join
    drain();
    check("t3_cnt", W'(frame_cnt), W'(3));
    if (hs_cyc.size() >= 2)
      check("t3_b2b", W'(hs_cyc[1] - hs_cyc[0]), W'(1));
    else
      check("t3_hs_count", W'(hs_cyc.size()), W'(3));

    // Test 4: mid-frame sof discards the partial frame
    do_reset();
    for (int i = 0; i < 100; i++)
      send_pix(8'($urandom), i == 0, 1'b0);
    for (int i = 0; i < W; i++) pat[i] = 8'($urandom);
    send_frame(1'b1, 1'b0);
    drain();
    check("t4_serr", W'(serr_seen), W'(1));
    check("t4_cnt", W'(frame_cnt), W'(1));

    // Test 5: random gaps and random consumer
    fr_mode = 2;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < W; i++) pat[i] = 8'($urandom);
      send_frame(f == 0, 1'b1);
    end
    drain();
    check("t5_cnt", W'(frame_cnt), W'(4));
    check("t5_sb_empty", W'(sb.size()), W'(0));

    // Test 6: async reset with a pending frame and a partial one
    fr_mode = 0;
    do_reset();
    for (int i = 0; i < W; i++) pat[i] = 8'($urandom);
    send_frame(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) send_pix(8'hFF, 1'b0, 1'b0);
    check("t6_pending", W'(frame_valid), W'(1));
    #2;
    xrst = 1'b1;
    #1;
    check("t6_async_fvalid", W'(frame_valid), W'(0));
    check("t6_async_bits", frame_bits, W'(0));
    check("t6_async_pready", W'(pix_ready), W'(0));
    fr_mode = 1;
    do_reset();
    for (int i = 0; i < W; i++) pat[i] = 8'($urandom);
    send_frame(1'b0, 1'b0);
    drain();
    check("t6_cnt", W'(frame_cnt), W'(1));
    check("t6_sb_empty", W'(sb.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
